// File: rtl/ifetch_pkg.sv
// Shared fetch-stage definitions: widths, PC select codes, fetch states, PC command payload.
package ifetch_pkg;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned OW = 8;

    // Next-value select understood by the program counter
    typedef enum logic [1:0] {
        PC_HOLD = 2'b00,
        PC_INC  = 2'b01,
        PC_JMP  = 2'b10,
        PC_REL  = 2'b11
    } pc_ctrl_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_HOLD = 2'b10,
        S_DROP = 2'b11
    } fetch_state_e;

    typedef struct packed {
        logic            en;
        pc_ctrl_e        ctrl;
        logic [OW-1:0]   offset;
    } pc_cmd_t;

endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage bus: PC control, instruction memory handshake, IR to decode, branch redirect.
interface ifetch_if;
    import ifetch_pkg::*;

    logic [AW-1:0] pc_in;
    logic          pc_en_out;
    logic [1:0]    pc_ctrl_out;
    logic [OW-1:0] offset_out;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [DW-1:0] imem_data;
    logic [DW-1:0] ir_out;
    logic          ir_valid;
    logic          ir_ready;
    logic          br_taken;
    logic          br_rel;
    logic [OW-1:0] br_offset;

    // Fetch stage side
    modport master (
        input  pc_in, imem_ack, imem_data, ir_ready, br_taken, br_rel, br_offset,
        output pc_en_out, pc_ctrl_out, offset_out, imem_req, imem_addr, ir_out, ir_valid
    );

    // PC / memory / decode / execute side
    modport slave (
        output pc_in, imem_ack, imem_data, ir_ready, br_taken, br_rel, br_offset,
        input  pc_en_out, pc_ctrl_out, offset_out, imem_req, imem_addr, ir_out, ir_valid
    );

endinterface

// File: rtl/ifetch.sv
// Instruction fetch: latch PC, fetch one word over req/ack, hold it in the IR until decode takes it.
// Drives the PC: increment on an accepted fetch, redirect on a taken branch.
module ifetch
    import ifetch_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    ifetch_if.master bus
);

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] imem_addr_q, imem_addr_d;
    logic [DW-1:0] ir_q, ir_d;
    logic          ir_valid_q, ir_valid_d;
    logic          imem_req_q, imem_req_d;
    pc_cmd_t       pc_cmd_c;

    // Request is asserted in every state that has a memory access outstanding
    assign imem_req_d = (state_d == S_REQ) || (state_d == S_DROP);

    // State, address and instruction registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            imem_addr_q <= AW'(0);
            ir_q        <= DW'(0);
            ir_valid_q  <= 1'b0;
            imem_req_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            imem_addr_q <= imem_addr_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            imem_req_q  <= imem_req_d;
        end
    end

    // Next-state, register updates and Mealy PC control; a taken branch overrides everything
    always_comb begin
        state_d         = state_q;
        imem_addr_d     = imem_addr_q;
        ir_d            = ir_q;
        ir_valid_d      = ir_valid_q;
        pc_cmd_c.en     = 1'b0;
        pc_cmd_c.ctrl   = PC_HOLD;
        pc_cmd_c.offset = OW'(0);

        unique case (state_q)
            S_IDLE: begin
                imem_addr_d = bus.pc_in;
                state_d     = S_REQ;
            end
            S_REQ: begin
                if (bus.imem_ack) begin
                    ir_d          = bus.imem_data;
                    ir_valid_d    = 1'b1;
                    pc_cmd_c.en   = 1'b1;
                    pc_cmd_c.ctrl = PC_INC;
                    state_d       = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.ir_ready) begin
                    ir_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            S_DROP: begin
                if (bus.imem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.br_taken) begin
            pc_cmd_c.en     = 1'b1;
            pc_cmd_c.ctrl   = bus.br_rel ? PC_REL : PC_JMP;
            pc_cmd_c.offset = bus.br_offset;
            ir_d            = ir_q;
            ir_valid_d      = 1'b0;
            // An unacknowledged request must still be drained before the next fetch
            if (((state_q == S_REQ) || (state_q == S_DROP)) && !bus.imem_ack) begin
                state_d = S_DROP;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = imem_addr_q;
    assign bus.ir_out      = ir_q;
    assign bus.ir_valid    = ir_valid_q;
    assign bus.pc_en_out   = pc_cmd_c.en;
    assign bus.pc_ctrl_out = pc_cmd_c.ctrl;
    assign bus.offset_out  = pc_cmd_c.offset;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: a transaction-level model plus a PC model drive pc_in,
// every cycle is compared on the falling edge, and literal pins anchor key cycles.
module tb_ifetch;
    import ifetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ifetch_if bus();

    ifetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Model: PC value, last launched address, IR contents, and outstanding-request flags
    logic [15:0] m_pc    = 16'h0000;
    logic [15:0] m_addr  = 16'h0000;
    logic [15:0] m_ir    = 16'h0000;
    logic        m_req   = 1'b0;
    logic        m_drop  = 1'b0;
    logic        m_valid = 1'b0;

    // Literal pins: index selects the observed signal
    localparam int unsigned P_REQ = 0, P_ADDR = 1, P_IR = 2, P_VAL = 3, P_EN = 4, P_CTRL = 5, P_OFF = 6;
    localparam int unsigned NP = 7;
    logic        pin_c_next [NP];
    logic [15:0] pin_v_next [NP];
    logic        pin_c_cur  [NP];
    logic [15:0] pin_v_cur  [NP];
    string       pn [NP] = '{"pin_req", "pin_addr", "pin_ir", "pin_valid", "pin_en", "pin_ctrl", "pin_off"};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model every cycle, then advance the model
    always @(negedge clk) begin : compare
        logic        e_en;
        logic [1:0]  e_ctrl;
        logic [7:0]  e_off;
        logic        idle;
        logic [15:0] pc_now;
        logic [15:0] act [NP];

        if (!rst) begin
            m_pc = 16'h0000; m_addr = 16'h0000; m_ir = 16'h0000;
            m_req = 1'b0; m_drop = 1'b0; m_valid = 1'b0;
        end

        e_en = 1'b0; e_ctrl = 2'b00; e_off = 8'h00;
        if (bus.br_taken) begin
            e_en = 1'b1; e_ctrl = bus.br_rel ? 2'b11 : 2'b10; e_off = bus.br_offset;
        end else if (rst && m_req && !m_drop && bus.imem_ack) begin
            e_en = 1'b1; e_ctrl = 2'b01;
        end

        chk("imem_req",  32'(bus.imem_req),    32'(m_req));
        chk("imem_addr", 32'(bus.imem_addr),   32'(m_addr));
        chk("ir_out",    32'(bus.ir_out),      32'(m_ir));
        chk("ir_valid",  32'(bus.ir_valid),    32'(m_valid));
        chk("pc_en",     32'(bus.pc_en_out),   32'(e_en));
        chk("pc_ctrl",   32'(bus.pc_ctrl_out), 32'(e_ctrl));
        chk("offset",    32'(bus.offset_out),  32'(e_off));

        act[P_REQ]  = 16'(bus.imem_req);
        act[P_ADDR] = bus.imem_addr;
        act[P_IR]   = bus.ir_out;
        act[P_VAL]  = 16'(bus.ir_valid);
        act[P_EN]   = 16'(bus.pc_en_out);
        act[P_CTRL] = 16'(bus.pc_ctrl_out);
        act[P_OFF]  = 16'(bus.offset_out);
        for (int i = 0; i < int'(NP); i++) begin
            if (pin_c_cur[i]) chk(pn[i], 32'(act[i]), 32'(pin_v_cur[i]));
        end

        if (rst) begin
            pc_now = m_pc;
            idle   = !m_req && !m_valid;
            if (e_en) begin
                case (e_ctrl)
                    2'b01:   m_pc = pc_now + 16'h0001;
                    2'b10:   m_pc = {8'h00, e_off};
                    2'b11:   m_pc = pc_now + 16'(e_off);
                    default: m_pc = pc_now;
                endcase
            end
            if (idle) m_addr = pc_now;
            if (bus.br_taken) begin
                m_valid = 1'b0;
                if (m_req && !bus.imem_ack) begin
                    m_drop = 1'b1;
                end else begin
                    m_req  = 1'b0;
                    m_drop = 1'b0;
                end
            end else if (idle) begin
                m_req  = 1'b1;
                m_drop = 1'b0;
            end else if (m_req) begin
                if (bus.imem_ack) begin
                    if (!m_drop) begin
                        m_ir    = bus.imem_data;
                        m_valid = 1'b1;
                    end
                    m_req  = 1'b0;
                    m_drop = 1'b0;
                end
            end else if (m_valid && bus.ir_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic pin(input int unsigned k, input logic [15:0] v);
        pin_c_next[k] = 1'b1;
        pin_v_next[k] = v;
    endtask

    // One cycle of stimulus; pins queued before the call apply to this cycle
    task automatic step(input logic r, input logic ack, input logic [15:0] data, input logic rdy,
                        input logic br, input logic rel, input logic [7:0] off);
        @(posedge clk);
        #1;
        rst           = r;
        bus.pc_in     = m_pc;
        bus.imem_ack  = ack;
        bus.imem_data = data;
        bus.ir_ready  = rdy;
        bus.br_taken  = br;
        bus.br_rel    = rel;
        bus.br_offset = off;
        for (int i = 0; i < int'(NP); i++) begin
            pin_c_cur[i]  = pin_c_next[i];
            pin_v_cur[i]  = pin_v_next[i];
            pin_c_next[i] = 1'b0;
            pin_v_next[i] = 16'h0000;
        end
    endtask

    initial begin
        for (int i = 0; i < int'(NP); i++) begin
            pin_c_next[i] = 1'b0; pin_v_next[i] = 16'h0000;
            pin_c_cur[i]  = 1'b0; pin_v_cur[i]  = 16'h0000;
        end
        bus.pc_in = 16'h0000; bus.imem_ack = 1'b0; bus.imem_data = 16'h0000;
        bus.ir_ready = 1'b0; bus.br_taken = 1'b0; bus.br_rel = 1'b0; bus.br_offset = 8'h00;

        // Reset values
        step(0, 0, 16'h0, 0, 0, 0, 8'h00);
        pin(P_REQ, 0); pin(P_ADDR, 0); pin(P_IR, 0); pin(P_VAL, 0); pin(P_EN, 0);
        step(0, 0, 16'h0, 0, 0, 0, 8'h00);

        // Zero-wait fetch of 16'hA001 from address 0
        pin(P_REQ, 0); pin(P_ADDR, 0);
        step(1, 0, 16'h0, 0, 0, 0, 8'h00);
        pin(P_REQ, 1); pin(P_ADDR, 0); pin(P_EN, 1); pin(P_CTRL, 16'h1);
        step(1, 1, 16'hA001, 0, 0, 0, 8'h00);

        // Decode stalls for 5 cycles; a stray ack in hold is ignored
        pin(P_IR, 16'hA001); pin(P_VAL, 1);
        step(1, 0, 16'h0, 0, 0, 0, 8'h00);
        step(1, 0, 16'h0, 0, 0, 0, 8'h00);
        step(1, 1, 16'h5555, 0, 0, 0, 8'h00);
        step(1, 0, 16'h0, 0, 0, 0, 8'h00);
        pin(P_IR, 16'hA001); pin(P_VAL, 1); pin(P_REQ, 0);
        step(1, 0, 16'h0, 0, 0, 0, 8'h00);
        step(1, 0, 16'h0, 1, 0, 0, 8'h00);
        pin(P_VAL, 0);
        step(1, 0, 16'h0, 0, 0, 0, 8'h00);

        // Fetch from pc+1 with ack delayed 3 cycles
        pin(P_REQ, 1); pin(P_ADDR, 16'h0001); pin(P_EN, 0);
        step(1, 0, 16'h0, 0, 0, 0, 8'h00);
        step(1, 0, 16'h0, 0, 0, 0, 8'h00);
        pin(P_REQ, 1); pin(P_ADDR, 16'h0001); pin(P_EN, 0);
        step(1, 0, 16'h0, 0, 0, 0, 8'h00);
        pin(P_ADDR, 16'h0001); pin(P_CTRL, 16'h1);
        step(1, 1, 16'hB002, 0, 0, 0, 8'h00);

        // Absolute branch to 0x40 while holding
        pin(P_EN, 1); pin(P_CTRL, 16'h2); pin(P_OFF, 16'h0040); pin(P_VAL, 1);
        step(1, 0, 16'h0, 0, 1, 0, 8'h40);
        pin(P_VAL, 0);
        step(1, 0, 16'h0, 0, 0, 0, 8'h00);
        pin(P_ADDR, 16'h0040); pin(P_REQ, 1);
        step(1, 1, 16'hC003, 0, 0, 0, 8'h00);

        // Branch with ready high still flushes; jump to 0x10
        pin(P_CTRL, 16'h2); pin(P_OFF, 16'h0010);
        step(1, 0, 16'h0, 1, 1, 0, 8'h10);
        pin(P_VAL, 0); pin(P_IR, 16'hC003);
        step(1, 0, 16'h0, 0, 0, 0, 8'h00);

        // Relative branch (+5) during an outstanding request at pc 0x10
        pin(P_ADDR, 16'h0010); pin(P_REQ, 1);
        step(1, 0, 16'h0, 0, 0, 0, 8'h00);
        pin(P_CTRL, 16'h3); pin(P_OFF, 16'h0005);
        step(1, 0, 16'h0, 0, 1, 1, 8'h05);
        pin(P_REQ, 1); pin(P_EN, 0);
        step(1, 1, 16'hDEAD, 0, 0, 0, 8'h00);
        pin(P_IR, 16'hC003); pin(P_VAL, 0); pin(P_REQ, 0);
        step(1, 0, 16'h0, 0, 0, 0, 8'h00);

        // Branch coincident with ack: no increment, word dropped
        pin(P_ADDR, 16'h0015); pin(P_CTRL, 16'h2); pin(P_OFF, 16'h0020);
        step(1, 1, 16'hE004, 0, 1, 0, 8'h20);
        pin(P_IR, 16'hC003); pin(P_VAL, 0);
        step(1, 0, 16'h0, 0, 0, 0, 8'h00);
        pin(P_ADDR, 16'h0020); pin(P_REQ, 1);
        step(1, 0, 16'h0, 0, 0, 0, 8'h00);

        // Reset mid-request, late acks ignored, refetch from 0
        pin(P_REQ, 0); pin(P_ADDR, 0); pin(P_IR, 0); pin(P_VAL, 0);
        step(0, 0, 16'h0, 0, 0, 0, 8'h00);
        step(0, 1, 16'h7777, 0, 0, 0, 8'h00);
        pin(P_IR, 0); pin(P_VAL, 0); pin(P_REQ, 0); pin(P_EN, 0);
        step(1, 1, 16'hF005, 0, 0, 0, 8'h00);
        pin(P_ADDR, 0); pin(P_REQ, 1); pin(P_CTRL, 16'h1);
        step(1, 1, 16'h1234, 0, 0, 0, 8'h00);
        pin(P_IR, 16'h1234); pin(P_VAL, 1);
        step(1, 0, 16'h0, 1, 0, 0, 8'h00);
        step(1, 0, 16'h0, 0, 0, 0, 8'h00);
        pin(P_ADDR, 16'h0001); pin(P_REQ, 1);
        step(1, 0, 16'h0, 0, 0, 0, 8'h00);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
